// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults and entry type for the instruction fetch queue
package fetch_pkg;
    localparam int FETCH_L = 10;
    localparam int FETCH_W = 9;
    localparam int FETCH_DEPTH = 4;
    typedef struct packed {
        logic [FETCH_L-1:0] pc;
        logic [FETCH_W-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetchq_mem.sv
// fetchq_mem: DEPTH-entry register array, one write port, asynchronous read
module fetchq_mem
    import fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         Clk,
    input  logic         we,
    input  logic [AW-1:0] waddr,
    input  fetch_entry_t wdata,
    input  logic [AW-1:0] raddr,
    output fetch_entry_t rdata
);
    fetch_entry_t mem [DEPTH];
    always_ff @(posedge Clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/inst_fetch_q.sv
// inst_fetch_q: instruction/PC queue between ROM and decode.
// FETCHQ_BYPASS_EN forwards PcIn/InstIn combinationally when the queue is empty.
module inst_fetch_q
    import fetch_pkg::*;
#(
    parameter int L = FETCH_L,
    parameter int W = FETCH_W,
    parameter int DEPTH = FETCH_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic         Flush,
    input  logic [L-1:0] PcIn,
    input  logic [W-1:0] InstIn,
    input  logic         DecReady,
    output logic [W-1:0] InstOut,
    output logic [L-1:0] PcOut,
    output logic         InstValid,
    output logic         Hold,
    output logic [CW-1:0] Count
);
    logic [AW-1:0] head, tail;
    logic [CW-1:0] count_q;
    logic push_ok, pop, byp, we, adv_head;
    fetch_entry_t rd;

    assign Count = count_q;
    assign Hold = count_q == CW'(DEPTH);
    assign push_ok = !Reset && !Flush && !Start && !Hold;
`ifdef FETCHQ_BYPASS_EN
    assign byp = count_q == '0 && push_ok;
    assign InstValid = count_q != '0 || byp;
    assign InstOut = byp ? InstIn : InstValid ? rd.inst : '0;
    assign PcOut = byp ? PcIn : InstValid ? rd.pc : '0;
`else
    assign byp = 1'b0;
    assign InstValid = count_q != '0;
    assign InstOut = InstValid ? rd.inst : '0;
    assign PcOut = InstValid ? rd.pc : '0;
`endif
    assign pop = InstValid && DecReady && !Flush;
    // a bypassed entry consumed in the same cycle never touches storage
    assign we = push_ok && !(byp && pop);
    assign adv_head = pop && !byp;

    always_ff @(posedge Clk)
        if (Reset || Flush) begin
            head <= '0;
            tail <= '0;
            count_q <= '0;
        end else begin
            if (we) tail <= tail + 1'b1;
            if (adv_head) head <= head + 1'b1;
            count_q <= count_q + CW'(we) - CW'(adv_head);
        end

    fetchq_mem #(.DEPTH(DEPTH)) u_mem (
        .Clk  (Clk),
        .we   (we),
        .waddr(tail),
        .wdata('{pc: PcIn, inst: InstIn}),
        .raddr(head),
        .rdata(rd)
    );
endmodule

// File: tb/tb_inst_fetch_q.sv
// tb_inst_fetch_q: scoreboard bench for inst_fetch_q (honours FETCHQ_BYPASS_EN)
module tb_inst_fetch_q;
    localparam int L = 10;
    localparam int W = 9;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [L-1:0] pc;
        logic [W-1:0] inst;
    } ent_t;

    logic Clk = 1'b0;
    logic Reset = 1'b1, Start = 1'b1, Flush = 1'b0, DecReady = 1'b0;
    logic [L-1:0] PcIn = '0;
    logic [W-1:0] InstIn = '0;
    logic [W-1:0] InstOut;
    logic [L-1:0] PcOut;
    logic InstValid, Hold;
    logic [$clog2(DEPTH):0] Count;

    ent_t sb[$];
    int checks = 0, errors = 0;
    logic [L-1:0] pc = '0;

    always #5 Clk = ~Clk;

    inst_fetch_q #(.L(L), .W(W), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Flush(Flush),
        .PcIn(PcIn), .InstIn(InstIn), .DecReady(DecReady),
        .InstOut(InstOut), .PcOut(PcOut), .InstValid(InstValid),
        .Hold(Hold), .Count(Count)
    );

    function automatic logic [W-1:0] rom(logic [L-1:0] a);
        return W'(a * 7 + 3);
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // drive one cycle, compare outputs with the model, then advance the model
    task automatic cyc(bit rst, bit st, bit fl, bit dr);
        bit empty, full, push_c, byp, pop_c;
        @(negedge Clk);
        Reset = rst; Start = st; Flush = fl; DecReady = dr;
        PcIn = pc; InstIn = rom(pc);
        #1;
        empty = sb.size() == 0;
        full = sb.size() == DEPTH;
        push_c = !rst && !fl && !st && !full;
        byp = 1'b0;
`ifdef FETCHQ_BYPASS_EN
        byp = empty && push_c;
`endif
        chk("valid", InstValid, !empty || byp);
        chk("hold", Hold, full);
        chk("count", Count, sb.size());
        if (byp) begin
            chk("byp_pc", PcOut, pc);
            chk("byp_inst", InstOut, rom(pc));
        end else if (!empty) begin
            chk("head_pc", PcOut, sb[0].pc);
            chk("head_inst", InstOut, sb[0].inst);
        end else begin
            chk("idle_pc", PcOut, 0);
            chk("idle_inst", InstOut, 0);
        end
        pop_c = (!empty || byp) && dr && !fl;
        if (rst || fl) sb.delete();
        else begin
            if (pop_c && !byp) void'(sb.pop_front());
            if (push_c && !(byp && pop_c)) sb.push_back('{pc, rom(pc)});
        end
        if (push_c) pc++;
        if (rst) pc = '0;
    endtask

    initial begin
        repeat (2) cyc(1, 1, 0, 0);
        repeat (4) cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        repeat (6) cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 1);
        repeat (8) cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        pc = 7;
        cyc(0, 0, 1, 0);
        pc = 20;
        cyc(0, 1, 0, 0);
        repeat (2) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 1);
        cyc(0, 1, 0, 0);
        pc = 5;
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        repeat (120)
            cyc($urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 14) == 0, 1'($urandom_range(0, 1)));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
